// File: rtl/cov_snapshot_feeder_if.sv
// Snapshot handshake and skewed array-edge bus between the upstream source,
// the feeder and the covariance array.
interface cov_snapshot_feeder_if #(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned DATA_WIDTH = 16
);
    localparam int unsigned BUS_W = NUM_CH * DATA_WIDTH;

    logic              in_valid;
    logic              in_ready;
    logic [BUS_W-1:0]  in_q;
    logic [BUS_W-1:0]  in_i;
    logic [BUS_W-1:0]  out_q;
    logic [BUS_W-1:0]  out_i;
    logic [NUM_CH-1:0] out_finish;

    modport master (
        output in_valid, in_q, in_i,
        input  in_ready, out_q, out_i, out_finish
    );

    modport slave (
        input  in_valid, in_q, in_i,
        output in_ready, out_q, out_i, out_finish
    );
endinterface

// File: rtl/cov_snapshot_feeder.sv
// Feeds I/Q snapshots into the covariance systolic array with a per-row skew,
// flags the last sample of each block and holds off input while the array drains.
module cov_snapshot_feeder #(
    parameter int unsigned NUM_CH       = 4,
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned SAMPLES_BITS = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic                  i_cont,
    cov_snapshot_feeder_if.slave  bus,
    output logic                  o_busy,
    output logic                  o_block_done
);
    localparam int unsigned BUS_W   = NUM_CH * DATA_WIDTH;
    localparam int unsigned STG_W   = 2 * DATA_WIDTH + 1;
    localparam int unsigned DRAIN_W = $clog2(NUM_CH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    state_e                  r_state;
    state_e                  w_state_nxt;
    logic [SAMPLES_BITS-1:0] r_cnt;
    logic [SAMPLES_BITS-1:0] w_cnt_nxt;
    logic [DRAIN_W-1:0]      r_drain_cnt;
    logic [DRAIN_W-1:0]      w_drain_nxt;
    logic                    r_in_ready;
    logic                    r_busy;
    logic                    r_block_done;
    logic                    w_done_nxt;

    logic                    w_accept;
    logic                    w_last_acc;
    logic [BUS_W-1:0]        w_out_q;
    logic [BUS_W-1:0]        w_out_i;
    logic [NUM_CH-1:0]       w_out_fin;

    assign w_accept   = bus.in_valid & r_in_ready;
    assign w_last_acc = w_accept & (r_cnt == {SAMPLES_BITS{1'b1}});

    // Block sequencing: state, sample counter and drain countdown
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_drain_nxt = r_drain_cnt;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = '0;
                end
            end
            S_RUN: begin
                if (w_accept) begin
                    w_cnt_nxt = r_cnt + SAMPLES_BITS'(1);
                    if (w_last_acc) begin
                        w_state_nxt = S_DRAIN;
                        w_drain_nxt = DRAIN_W'(NUM_CH);
                    end
                end
            end
            S_DRAIN: begin
                if (r_drain_cnt == '0) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = i_cont ? S_RUN : S_IDLE;
                end else begin
                    w_drain_nxt = r_drain_cnt - DRAIN_W'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_drain_cnt  <= '0;
            r_in_ready   <= 1'b0;
            r_busy       <= 1'b0;
            r_block_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_drain_cnt  <= w_drain_nxt;
            r_in_ready   <= (w_state_nxt == S_RUN);
            r_busy       <= (w_state_nxt != S_IDLE);
            r_block_done <= w_done_nxt;
        end
    end

    // Row k sees its sample k edges after acceptance; gaps load zeros
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [STG_W-1:0] r_stg [0:k];
        logic [STG_W-1:0] w_stg0;

        assign w_stg0 = w_accept ? {w_last_acc,
                                    bus.in_q[k*DATA_WIDTH +: DATA_WIDTH],
                                    bus.in_i[k*DATA_WIDTH +: DATA_WIDTH]}
                                 : '0;

        always_ff @(posedge i_clk) begin
            if (i_rst) r_stg[0] <= '0;
            else       r_stg[0] <= w_stg0;
        end

        for (genvar s = 1; s <= k; s++) begin : g_stg
            always_ff @(posedge i_clk) begin
                if (i_rst) r_stg[s] <= '0;
                else       r_stg[s] <= r_stg[s-1];
            end
        end

        assign w_out_fin[k]                           = r_stg[k][2*DATA_WIDTH];
        assign w_out_q[k*DATA_WIDTH +: DATA_WIDTH]    = r_stg[k][2*DATA_WIDTH-1:DATA_WIDTH];
        assign w_out_i[k*DATA_WIDTH +: DATA_WIDTH]    = r_stg[k][DATA_WIDTH-1:0];
    end

    assign bus.in_ready   = r_in_ready;
    assign bus.out_q      = w_out_q;
    assign bus.out_i      = w_out_i;
    assign bus.out_finish = w_out_fin;
    assign o_busy         = r_busy;
    assign o_block_done   = r_block_done;
endmodule

// File: tb/tb_cov_snapshot_feeder.sv
// Randomized bench for cov_snapshot_feeder: an edge-indexed history of accepted
// snapshots predicts every skewed output, plus the block/drain timeline.
module tb_cov_snapshot_feeder;
    localparam int unsigned NC   = 4;
    localparam int unsigned DW   = 16;
    localparam int unsigned SB   = 2;
    localparam int unsigned BW   = NC * DW;
    localparam int          BLK  = 1 << SB;
    localparam int          MAXC = 2048;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic start;
    logic cont;
    logic busy;
    logic block_done;

    cov_snapshot_feeder_if #(.NUM_CH(NC), .DATA_WIDTH(DW)) bus ();

    cov_snapshot_feeder #(
        .NUM_CH(NC), .DATA_WIDTH(DW), .SAMPLES_BITS(SB)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_cont       (cont),
        .bus          (bus),
        .o_busy       (busy),
        .o_block_done (block_done)
    );

    int n_vec = 0;
    int n_err = 0;
    int t     = 0;

    // Reference: what was accepted at each edge, and the block timeline
    logic [BW-1:0] hq [MAXC];
    logic [BW-1:0] hi [MAXC];
    logic          hf [MAXC];
    int            mode      = 0;  // 0 idle, 1 accepting, 2 waiting for array drain
    int            nacc      = 0;
    int            done_edge = -1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h (edge %0d)", tag, obs, exp, t);
        end
    endtask

    task automatic cyc(input logic r, input logic s, input logic c, input logic v);
        logic          acc;
        logic          e_done;
        logic [BW-1:0] dq;
        logic [BW-1:0] di;
        logic [BW-1:0] eq;
        logic [BW-1:0] ei;
        logic [NC-1:0] ef;
        dq = {$urandom, $urandom};
        di = {$urandom, $urandom};
        rst          = r;
        start        = s;
        cont         = c;
        bus.in_valid = v;
        bus.in_q     = dq;
        bus.in_i     = di;
        @(posedge clk);
        acc    = v && (mode == 1) && !r;
        e_done = 1'b0;
        hq[t]  = acc ? dq : '0;
        hi[t]  = acc ? di : '0;
        hf[t]  = 1'b0;
        if (r) begin
            mode = 0;
            nacc = 0;
            for (int k = 1; k < NC; k++) begin
                if (t - k >= 0) begin
                    hq[t-k] = '0;
                    hi[t-k] = '0;
                    hf[t-k] = 1'b0;
                end
            end
        end else begin
            case (mode)
                0: if (s) begin mode = 1; nacc = 0; end
                1: if (acc) begin
                    nacc++;
                    if (nacc == BLK) begin
                        hf[t]     = 1'b1;
                        mode      = 2;
                        done_edge = t + NC + 1;
                    end
                end
                default: if (t == done_edge) begin
                    e_done = 1'b1;
                    mode   = c ? 1 : 0;
                    nacc   = 0;
                end
            endcase
        end
        #1;
        eq = '0;
        ei = '0;
        ef = '0;
        for (int k = 0; k < NC; k++) begin
            if (t - k >= 0) begin
                eq[k*DW +: DW] = hq[t-k][k*DW +: DW];
                ei[k*DW +: DW] = hi[t-k][k*DW +: DW];
                ef[k]          = hf[t-k];
            end
        end
        chk("in_ready",   64'(bus.in_ready),   64'(mode == 1));
        chk("busy",       64'(busy),           64'(mode != 0));
        chk("block_done", 64'(block_done),     64'(e_done));
        chk("out_q",      64'(bus.out_q),      64'(eq));
        chk("out_i",      64'(bus.out_i),      64'(ei));
        chk("out_finish", 64'(bus.out_finish), 64'(ef));
        t++;
    endtask

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        cont         = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_q     = '0;
        bus.in_i     = '0;

        repeat (2) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        // valid without start must be ignored
        repeat (5) cyc(1'b0, 1'b0, 1'b0, 1'b1);
        // back-to-back blocks under constant valid and cont
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        repeat (30) cyc(1'b0, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (12) cyc(1'b0, 1'b0, 1'b0, 1'b1);
        // random bubbles, starts and cont
        repeat (400) cyc(1'b0, 1'($urandom_range(0, 9) == 0),
                         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        // same with occasional mid-block reset
        repeat (300) cyc(1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 4) == 0),
                         1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
